// File: rtl/lut_neuron_pipe_if.sv
// Lookup / configuration bus of the LUT neuron. The master drives requests,
// writes and result back-pressure; the slave (the LUT block) answers.
interface lut_neuron_pipe_if #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1
);
  // Lookup request channel
  logic                in_valid;
  logic                in_ready;
  logic [IN_BITS-1:0]  in_data;
  // Lookup result channel
  logic                out_valid;
  logic                out_ready;
  logic [OUT_BITS-1:0] out_data;
  // Table write channel
  logic                cfg_we;
  logic [IN_BITS-1:0]  cfg_addr;
  logic [OUT_BITS-1:0] cfg_data;
  logic                cfg_ready;
  // Status
  logic                busy;

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data, cfg_ready, busy
  );

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data, cfg_ready, busy
  );
endinterface

// File: rtl/lut_neuron_pipe.sv
// LUT neuron: a 2^IN_BITS x OUT_BITS lookup table held in distributed memory.
// After reset the whole table is swept to CLR_VAL, one entry per cycle; then
// the block serves single-cycle-latency lookups with a valid/ready output
// register and accepts table writes on the cfg channel.
module lut_neuron_pipe #(
  parameter int                  IN_BITS  = 8,
  parameter int                  OUT_BITS = 1,
  parameter logic [OUT_BITS-1:0] CLR_VAL  = '0
) (
  input logic              clk,
  input logic              rst,
  lut_neuron_pipe_if.slave bus
);

  localparam int DEPTH = 1 << IN_BITS;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [IN_BITS-1:0]  cnt_q, cnt_d;
  logic [OUT_BITS-1:0] mem_q [DEPTH];

  logic                out_valid_q, out_valid_d;
  logic [OUT_BITS-1:0] out_data_q,  out_data_d;

  logic                mem_we;
  logic [IN_BITS-1:0]  mem_waddr;
  logic [OUT_BITS-1:0] mem_wdata;
  logic                in_accept;
  logic                run;

  // State and clear-counter register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register in the block samples the pre-edge values of the others.
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: leave CLEAR on the cycle the last entry is written; the
  // counter wrapping back to 0 never re-enters CLEAR.
  always_comb begin
    // NOTE: every combinational output is given a default first, so no path
    // through the block leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IN_BITS'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Outputs of the control FSM: status, ready flags and the table write port.
  always_comb begin
    run       = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = CLR_VAL;
    unique case (state_q)
      CLEAR: begin
        // Clear sweep owns the write port; cfg writes are dropped here.
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = CLR_VAL;
      end
      RUN: begin
        run       = 1'b1;
        mem_we    = bus.cfg_we;
        mem_waddr = bus.cfg_addr;
        mem_wdata = bus.cfg_data;
      end
      default: begin
        run = 1'b0;
      end
    endcase
  end

  // Table storage: one write port (clear sweep or cfg), read at lookup accept.
  always_ff @(posedge clk) begin
    // NOTE: the table has no reset branch; its contents are defined by the
    // clear sweep that follows every reset, which keeps it in plain LUT RAM.
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // A lookup is taken when the output register is empty or being drained.
  assign in_accept = bus.in_valid && bus.in_ready;

  // Output register next-state: load on accept, drop valid after a drain
  // with no new lookup, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (in_accept) begin
      out_valid_d = 1'b1;
      // Reading the registered table gives the pre-write value when a cfg
      // write hits the same address in this cycle.
      out_data_d  = mem_q[bus.in_data];
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register; reset discards any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.busy      = !run;
  assign bus.cfg_ready = run;
  assign bus.in_ready  = run && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_lut_neuron_pipe.sv
// Directed bench for lut_neuron_pipe with IN_BITS=8, OUT_BITS=1. CLR_VAL is
// set to 1 so the cleared table differs from the parity pattern and from a
// zero-initialised memory.
module tb_lut_neuron_pipe;

  localparam int         IN_BITS  = 8;
  localparam int         OUT_BITS = 1;
  localparam logic [0:0] CLR      = 1'b1;

  logic clk;
  logic rst;

  int pass_cnt;
  int total_cnt;

  lut_neuron_pipe_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) bus ();

  lut_neuron_pipe #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS),
    .CLR_VAL (CLR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic par(input int a);
    logic [7:0] a8;
    a8 = a[7:0];
    return ^a8;
  endfunction

  // Global guard so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    bit  ready_in_clear;
    pass_cnt  = 0;
    total_cnt = 0;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;

    // Reset state
    rst = 1'b1;
    step();
    check("rst_out_valid", 16'(bus.out_valid), 16'h0);
    check("rst_out_data",  16'(bus.out_data),  16'h0);
    check("rst_in_ready",  16'(bus.in_ready),  16'h0);
    check("rst_cfg_ready", 16'(bus.cfg_ready), 16'h0);
    check("rst_busy",      16'(bus.busy),      16'h1);

    // Clear timing, with a lookup held pending and a write attempted to 0x10
    rst          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 8'h10;
    bus.cfg_data = ~CLR;
    n = 0;
    ready_in_clear = 1'b0;
    while (bus.busy && n < 400) begin
      if (bus.in_ready || bus.cfg_ready) ready_in_clear = 1'b1;
      n++;
      step();
    end
    bus.cfg_we = 1'b0;
    check("clear_cycles",   16'(n),              16'd256);
    check("ready_in_clear", 16'(ready_in_clear), 16'h0);
    check("run_in_ready",   16'(bus.in_ready),   16'h1);
    check("run_cfg_ready",  16'(bus.cfg_ready),  16'h1);
    step();
    check("first_result", 16'({bus.out_valid, bus.out_data}), 16'({1'b1, CLR}));
    bus.in_data = 8'h10;
    step();
    check("clear_write_ignored", 16'({bus.out_valid, bus.out_data}), 16'({1'b1, CLR}));
    bus.in_valid = 1'b0;
    step();
    check("valid_drop", 16'(bus.out_valid), 16'h0);

    // Program parity into every entry
    for (int a = 0; a < 256; a++) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 8'(a);
      bus.cfg_data = par(a);
      step();
    end
    bus.cfg_we = 1'b0;

    // Back-to-back stream of all addresses
    bus.in_valid = 1'b1;
    for (int a = 0; a < 256; a++) begin
      bus.in_data = 8'(a);
      step();
      check($sformatf("stream_%0d", a), 16'({bus.out_valid, bus.out_data}),
            16'({1'b1, par(a)}));
    end
    bus.in_valid = 1'b0;
    step();
    check("stream_end_valid", 16'(bus.out_valid), 16'h0);

    // Back-pressure: addresses 1..4 (parity 1,1,0,1)
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    step();
    check("bp_res1", 16'({bus.out_valid, bus.out_data}), 16'({1'b1, 1'b1}));
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_data = (k == 1) ? 8'h07 : 8'h03;  // ignored while stalled
      #1;
      check($sformatf("bp_in_ready_%0d", k), 16'(bus.in_ready), 16'h0);
      step();
      check($sformatf("bp_hold_%0d", k), 16'({bus.out_valid, bus.out_data}),
            16'({1'b1, 1'b1}));
    end
    bus.out_ready = 1'b1;
    bus.in_data   = 8'h02;
    step();
    check("bp_res2", 16'({bus.out_valid, bus.out_data}), 16'({1'b1, 1'b1}));
    bus.in_data = 8'h03;
    step();
    check("bp_res3", 16'({bus.out_valid, bus.out_data}), 16'({1'b1, 1'b0}));
    bus.in_data = 8'h04;
    step();
    check("bp_res4", 16'({bus.out_valid, bus.out_data}), 16'({1'b1, 1'b1}));
    bus.in_valid = 1'b0;
    step();
    check("bp_drain", 16'(bus.out_valid), 16'h0);

    // Write/read collision on 0x5A
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 8'h5A;
    bus.cfg_data = 1'b0;
    step();
    bus.cfg_data = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    step();
    check("collide_old", 16'({bus.out_valid, bus.out_data}), 16'({1'b1, 1'b0}));
    bus.cfg_we = 1'b0;
    step();
    check("collide_new", 16'({bus.out_valid, bus.out_data}), 16'({1'b1, 1'b1}));

    // Reset in the middle of a stream
    bus.in_data = 8'h03;
    step();
    check("pre_rst_valid", 16'({bus.out_valid, bus.out_data}), 16'({1'b1, 1'b0}));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 16'(bus.out_valid), 16'h0);
    check("mid_rst_busy",  16'(bus.busy),      16'h1);
    n = 0;
    while (!bus.in_ready && n < 400) begin
      n++;
      step();
    end
    check("reclear_cycles", 16'(n), 16'd256);
    step();
    check("reclear_addr3", 16'({bus.out_valid, bus.out_data}), 16'({1'b1, CLR}));
    bus.in_data = 8'h00;
    step();
    check("reclear_addr0", 16'({bus.out_valid, bus.out_data}), 16'({1'b1, CLR}));
    bus.in_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/lut_neuron_pipe.md
LUT_NEURON_PIPE -- requirements
Module: lut_neuron_pipe

Interface
REQ-001 The block SHALL have parameter IN_BITS, default 8, the lookup address width.
REQ-002 The block SHALL have parameter OUT_BITS, default 1, the lookup data width.
REQ-003 The block SHALL have parameter CLR_VAL, default 0 (OUT_BITS wide), the value written to every entry during clear.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-005 Port list (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, synchronous active-high reset
- in_valid, in, 1, lookup request valid
- in_ready, out, 1, lookup request accepted
- in_data, in, IN_BITS, lookup address
- out_valid, out, 1, result valid
- out_ready, in, 1, downstream accepts result
- out_data, out, OUT_BITS, table entry
- cfg_we, in, 1, table write strobe
- cfg_addr, in, IN_BITS, write address
- cfg_data, in, OUT_BITS, write data
- cfg_ready, out, 1, writes accepted
- busy, out, 1, clear in progress

Function
REQ-006 The block SHALL hold a table of 2^IN_BITS entries, each OUT_BITS wide, stored as distributed memory.
REQ-007 The control state machine SHALL have two states, CLEAR and RUN.
REQ-008 Reset SHALL enter CLEAR with the clear counter at 0.
REQ-009 In CLEAR, the block SHALL write CLR_VAL to the entry at the counter address on each cycle and then increment the counter.
REQ-010 The clear SHALL take exactly 2^IN_BITS cycles.
REQ-011 On the cycle the counter writes address 2^IN_BITS-1, the next state SHALL be RUN. Counter wrap to 0 SHALL NOT restart the clear.
REQ-012 busy SHALL be 1 in CLEAR and 0 in RUN.
REQ-013 cfg_ready and in_ready SHALL be 0 in CLEAR.
REQ-014 cfg_we asserted in CLEAR SHALL be ignored, and the table SHALL NOT change because of it.
REQ-015 In RUN, cfg_ready SHALL be 1, and cfg_we=1 SHALL write cfg_data to entry cfg_addr at the clock edge.
REQ-016 in_ready SHALL equal (state==RUN) and (!out_valid or out_ready).
REQ-017 A lookup is accepted when in_valid and in_ready are both 1.
REQ-018 The result of an accepted lookup SHALL appear on out_data with out_valid=1 on the next cycle, giving a latency of exactly 1 cycle.
REQ-019 The block SHALL sustain 1 lookup per cycle while out_ready=1.
REQ-020 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable and no new lookup SHALL be accepted.
REQ-021 out_valid SHALL fall to 0 after a handshake cycle (out_valid and out_ready) in which no new lookup is accepted.
REQ-022 If a write and a lookup to the same address occur in the same cycle, the lookup SHALL return the pre-write value. The new value SHALL be visible to lookups accepted on later cycles.
REQ-023 A write SHALL NOT alter an out_data value that is already registered.
REQ-024 in_data SHALL be sampled only on acceptance, and changes to in_data while in_ready=0 SHALL have no effect.

Reset
REQ-025 On rst=1 at a clock edge, the following SHALL hold on the next cycle: out_valid=0, out_data=0, in_ready=0, cfg_ready=0, busy=1, state=CLEAR, counter=0.
REQ-026 Reset asserted mid-clear or mid-RUN SHALL restart the full clear.
REQ-027 Reset SHALL discard any pending result.
REQ-028 After reset, the table contents SHALL be undefined only until the clear completes, and SHALL equal CLR_VAL everywhere afterwards.

Verification
REQ-029 Clear timing (IN_BITS=8): release rst, then hold in_valid=1 and in_data=8'h00. busy SHALL stay 1 for exactly 256 cycles. in_ready SHALL rise on cycle 257. The first out_data SHALL equal CLR_VAL.
REQ-030 Program and stream: write all 256 entries, with entry a set to bit parity(a). Then stream addresses 0..255 back-to-back with out_ready=1. The bench SHALL see 256 results, one per cycle, each equal to parity(addr), with a 1-cycle lag.
REQ-031 Back-pressure: stream addresses 1..4 while holding out_ready=0 for 3 cycles after the first result. out_data SHALL hold the value for address 1 and in_ready=0 during the hold. All 4 results SHALL be delivered in order with none lost.
REQ-032 Write/read collision: entry 8'h5A=0. In one cycle, drive cfg_we=1 with cfg_addr=8'h5A and cfg_data=1, plus a lookup of 8'h5A. The result SHALL be 0. A lookup of 8'h5A on the next cycle SHALL return 1.
REQ-033 Reset mid-operation: assert rst for 1 cycle during a stream with out_valid=1. On the next cycle out_valid SHALL be 0 and busy SHALL be 1. A lookup after 256 cycles SHALL return CLR_VAL regardless of earlier writes.
REQ-034 Write ignored in CLEAR: drive cfg_we=1 with cfg_addr=8'h10 and cfg_data=1 during the clear. After the clear, a lookup of 8'h10 SHALL return CLR_VAL.
